// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine over a full 128-bit state.
// Transforms COLS_PER_CYCLE columns per clock and holds the result until it is accepted.
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter bit          INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned NumGroups = (COLS_PER_CYCLE == 0) ? 4 : 4 / COLS_PER_CYCLE;
  localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column; bytes a0..a3 from MSB to LSB.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m3[i] = x2[i] ^ a[i];
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    if (inv) begin
      res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end else begin
      res[31:24] = x2[0] ^ m3[1] ^ a[2]  ^ a[3];
      res[23:16] = a[0]  ^ x2[1] ^ m3[2] ^ a[3];
      res[15:8]  = a[0]  ^ a[1]  ^ x2[2] ^ m3[3];
      res[7:0]   = m3[0] ^ a[1]  ^ a[2]  ^ x2[3];
    end
    return res;
  endfunction

  state_e            st_q, st_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [127:0]      work_q, work_d;
  logic              inv_q, inv_d;

  logic [31:0] cols_cur [4];
  logic [31:0] cols_nxt [4];
  logic [1:0]  col_idx;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols_cur[c] = work_q[127-32*c -: 32];
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;
    col_idx = 2'd0;
    for (int c = 0; c < 4; c++) begin
      cols_nxt[c] = cols_cur[c];
    end

    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          work_d = in_state;
          inv_d  = INV_EN ? in_inv : 1'b0;
          cnt_d  = '0;
          st_d   = StRun;
        end
      end
      StRun: begin
        // Only this group's columns pass through the transform units.
        for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
          col_idx           = 2'((32'(cnt_q) * COLS_PER_CYCLE) + 32'(j));
          cols_nxt[col_idx] = mix_col(cols_cur[col_idx], inv_q);
        end
        for (int c = 0; c < 4; c++) begin
          work_d[127-32*c -: 32] = cols_nxt[c];
        end
        if (cnt_q == CntW'(NumGroups - 1)) begin
          st_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= StIdle;
      cnt_q  <= '0;
      work_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
      inv_q  <= inv_d;
    end
  end

  assign in_ready  = (st_q == StIdle) && !rst;
  assign out_valid = (st_q == StDone);
  assign busy      = (st_q != StIdle);
  assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: C=1/2/4 with inverse, plus C=1 forward-only.
module tb_mix_columns_seq;

  localparam logic [127:0] VecA  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] VecB  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] Vec80 = 128'h80808080_80808080_80808080_80808080;
  localparam logic [127:0] VecC6 = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
  localparam logic [127:0] Vec14 = 128'h01020304_01020304_01020304_01020304;
  localparam logic [127:0] Vec14F = 128'h0304090a_0304090a_0304090a_0304090a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  [4];
  logic         in_inv    [4];
  logic         out_ready [4];
  logic [127:0] in_state  [4];
  logic         in_ready  [4];
  logic         out_valid [4];
  logic         busy      [4];
  logic [127:0] out_state [4];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(
      .COLS_PER_CYCLE(1 << g),
      .INV_EN        (1'b1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_state (in_state[g]),
      .in_inv   (in_inv[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_state(out_state[g]),
      .busy     (busy[g])
    );
  end

  mix_columns_seq #(
    .COLS_PER_CYCLE(1),
    .INV_EN        (1'b0)
  ) u_dut_fwd (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid[3]),
    .in_ready (in_ready[3]),
    .in_state (in_state[3]),
    .in_inv   (in_inv[3]),
    .out_valid(out_valid[3]),
    .out_ready(out_ready[3]),
    .out_state(out_state[3]),
    .busy     (busy[3])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 1) ? 2 : (d == 2) ? 1 : 4;
  endfunction

  // Reference uses a bitwise shift-and-add multiply against the coefficient rows.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] st, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   r;
    logic [127:0] res = '0;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = st[127-32*c-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r ^= gf_mul(a[j], coef[(j - i + 4) % 4]);
        res[127-32*c-8*i -: 8] = r;
      end
    end
    return res;
  endfunction

  // Entered and left at #1 after a rising edge with the instance idle.
  task automatic run_block(input int d, input logic [127:0] st, input logic inv,
                           input logic [127:0] exp, input string tag);
    int lat = 0;
    check_eq({tag, "_rdy"}, 128'(in_ready[d]), 128'(1));
    in_valid[d] = 1'b1;
    in_state[d] = st;
    in_inv[d]   = inv;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    while (!out_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 128'(lat), 128'(n_of(d)));
    check_eq({tag, "_data"}, out_state[d], exp);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check_eq({tag, "_vld_clr"}, 128'(out_valid[d]), 128'(0));
    check_eq({tag, "_rdy_back"}, 128'(in_ready[d]), 128'(1));
  endtask

  logic [127:0] exp_q [$];

  initial begin
    logic [127:0] cur_st;
    logic         cur_inv;
    logic         fire;
    int           sent, recv, cyc, last_t, lat;

    for (int d = 0; d < 4; d++) begin
      in_valid[d]  = 1'b0;
      in_inv[d]    = 1'b0;
      out_ready[d] = 1'b0;
      in_state[d]  = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_rdy", 128'(in_ready[0]), 128'(0));
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("rst_vld%0d", d), 128'(out_valid[d]), 128'(0));
      check_eq($sformatf("rst_st%0d", d), out_state[d], 128'(0));
      check_eq($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'(0));
      check_eq($sformatf("rst_rdy%0d", d), 128'(in_ready[d]), 128'(1));
    end
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++) begin
      run_block(d, VecA, 1'b0, VecB, $sformatf("fwd_c%0d", 1 << d));
      run_block(d, VecB, 1'b1, VecA, $sformatf("inv_c%0d", 1 << d));
    end
    run_block(3, VecB, 1'b1, model_mix(VecB, 1'b0), "noinv");

    run_block(0, Vec80, 1'b0, Vec80, "edge80");
    run_block(0, Vec14, 1'b0, Vec14F, "edge14_fwd");
    run_block(0, Vec14F, 1'b1, Vec14, "edge14_inv");

    // Backpressure on C=2 with a second block waiting upstream
    in_valid[1] = 1'b1; in_state[1] = VecA; in_inv[1] = 1'b0;
    @(posedge clk); #1;
    in_state[1] = VecB; in_inv[1] = 1'b1;
    lat = 0;
    while (!out_valid[1] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp_lat", 128'(lat), 128'(2));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_vld", 128'(out_valid[1]), 128'(1));
      check_eq("bp_data", out_state[1], VecB);
      check_eq("bp_rdy", 128'(in_ready[1]), 128'(0));
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    check_eq("bp_xfer_vld", 128'(out_valid[1]), 128'(0));
    check_eq("bp_xfer_rdy", 128'(in_ready[1]), 128'(1));
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    check_eq("bp_second_busy", 128'(busy[1]), 128'(1));
    lat = 0;
    while (!out_valid[1] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp_second_lat", 128'(lat), 128'(2));
    check_eq("bp_second_data", out_state[1], VecA);
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;

    // Back-to-back random blocks on C=1, sink always ready
    out_ready[0] = 1'b1;
    cur_st  = {$urandom, $urandom, $urandom, $urandom};
    cur_inv = 1'($urandom_range(0, 1));
    in_valid[0] = 1'b1; in_state[0] = cur_st; in_inv[0] = cur_inv;
    sent = 0; recv = 0; cyc = 0; last_t = -1;
    while (recv < 6 && cyc < 200) begin
      fire = in_valid[0] && in_ready[0];
      @(posedge clk); #1;
      cyc++;
      if (fire) begin
        exp_q.push_back(model_mix(cur_st, cur_inv));
        sent++;
        if (sent < 6) begin
          cur_st  = {$urandom, $urandom, $urandom, $urandom};
          cur_inv = 1'($urandom_range(0, 1));
          in_state[0] = cur_st; in_inv[0] = cur_inv;
        end else begin
          in_valid[0] = 1'b0;
        end
      end
      if (out_valid[0]) begin
        if (exp_q.size() > 0) check_eq("rnd_data", out_state[0], exp_q.pop_front());
        else check_eq("rnd_spurious", 128'(1), 128'(0));
        if (last_t >= 0) check_eq("rnd_period", 128'(cyc - last_t), 128'(6));
        last_t = cyc;
        recv++;
      end
    end
    check_eq("rnd_count", 128'(recv), 128'(6));
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    @(posedge clk); #1;

    // Reset during RUN discards the block
    in_valid[0] = 1'b1; in_state[0] = VecA; in_inv[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rdy_forced", 128'(in_ready[2]), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_vld", 128'(out_valid[0]), 128'(0));
    check_eq("mid_rst_st", out_state[0], 128'(0));
    check_eq("mid_rst_busy", 128'(busy[0]), 128'(0));
    check_eq("mid_rst_rdy", 128'(in_ready[0]), 128'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("mid_rst_no_vld", 128'(out_valid[0]), 128'(0));
    end
    run_block(0, VecC6, 1'b0, VecC6, "post_rst_c6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
